redmule_x_stream_buffer: RTL
============================

Name: redmule_x_stream_buffer

Overview:
- Next-generation X-operand staging buffer for the RedMulE datapath, sitting between the streamer's X load port and the engine's X inputs.
- Stores one tile of up to W rows in a pad memory, then transposes pad columns into NB staging banks of H rows each. NB is parametric; the previous generation was fixed ping-pong.
- Adds a valid/ready load handshake, out_valid gating, and zero-masking of both rows and columns.

Parameters:
- DW, 288, load word width in bits.
- BITW, 16, element width in bits.
- H, 4, rows per bank (PE rows).
- W, 12, elements per buffer row (array width).
- NB, 2, number of staging banks (>=2, power of two).
- TOT_DEPTH, DW/BITW = 18, pad columns per loaded row.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear; returns block to IDLE
- start_i  in  1  latches cfg_* in IDLE
- cfg_width_i  in  $clog2(W)+1  valid loaded rows, 1..W
- cfg_height_i  in  $clog2(TOT_DEPTH)+1  valid columns, 1..TOT_DEPTH
- cfg_slots_i  in  $clog2(TOT_DEPTH)+1  columns transferred per tile, cfg_height..TOT_DEPTH
- load_valid_i  in  1  load word valid
- load_ready_o  out  1  pad accepts a word
- load_data_i  in  DW  one X row
- shift_i  in  1  consumer takes the current row of the read bank
- out_valid_o  out  1  read bank holds H valid rows
- x_buffer_o  out  W*H*BITW  [W][H][BITW], current read bank
- tile_done_o  out  1  one-cycle pulse when the last bank of a tile is released
- busy_o  out  1  state != IDLE
- perf_stall_o  out  32  stall counter (optional feature)

Behaviour:
- Reset and clear values: all outputs 0, state IDLE, all counters and pointers 0, all bank_valid bits 0.
- IDLE -> LOAD when start_i is high; cfg latched in that cycle.
- LOAD:
  - load_ready_o = (w_idx < cfg_width).
  - A handshake writes pad row w_idx and increments it.
  - w_idx == cfg_width -> XFER.
- XFER, once per cycle while the write bank is not valid:
  - Read pad column c and write bank row (wb, hw).
  - Element w is zeroed if w >= cfg_width; the whole row is zeroed if c >= cfg_height.
  - hw wraps at H-1; on wrap, set bank_valid[wb] and advance wb modulo NB.
  - c == cfg_slots with hw != 0 -> FLUSH.
  - c == cfg_slots with hw == 0 -> DRAIN.
- FLUSH: write zero rows, one per cycle, until hw wraps; set that bank valid -> DRAIN.
- DRAIN: once all bank_valid bits are 0, pulse tile_done_o, reset w_idx and c -> LOAD.
- Load of the next tile begins only after DRAIN; the pad is single-buffered.
- Read side:
  - out_valid_o = bank_valid[rb].
  - shift_i && out_valid_o advances hr. On hr == H-1, clear bank_valid[rb] and advance rb.
  - shift_i while out_valid_o = 0 is ignored.
- Simultaneous events:
  - Set and clear of different banks in the same cycle: both take effect.
  - Same-bank set and clear in one cycle cannot occur, because writes target only invalid banks.
- First-valid latency: out_valid_o rises H cycles after entering XFER, given no read stalls.
- clear_i mid-operation: state and pointers reset next cycle. Pad and bank contents are retained but invalid.
- Pointer arithmetic is unsigned. Comparisons use the widened cfg widths, with no truncation.

Optional Feature:
- Macro: REDMULE_X_STREAM_BUF_PERF_EN.
- With the macro defined:
  - perf_stall_o counts cycles with busy_o && !out_valid_o.
  - Saturates at 2^32-1.
  - Cleared by clear_i and on start_i.
- Without the macro: perf_stall_o is tied to 0 and no counter flops are present.

Decomposition:
- redmule_pkg holds:
  - x_stream_state_e (IDLE, LOAD, XFER, FLUSH, DRAIN);
  - x_stream_cfg_t (width, height, slots);
  - X_STREAM_NB_DEFAULT.
- Sub-module redmule_x_stream_banks: NB*H*W storage with a single write port (bank, row, data) and full-bank output selected by rb.
- The pad reuses redmule_x_pad_scm.

Test Plan:
- Full tile, width=12, height=4, slots=4: 12 loads, then out_valid after 4 XFER cycles. 4 shifts return columns 0..3 transposed; tile_done pulses once.
- Partial width=5: x_buffer_o[w] = 0 for w >= 5 in every row.
- height=3, slots=4: row 3 of the bank is all zeros.
- slots=6, H=4: bank0 holds columns 0..3; bank1 holds columns 4,5 plus 2 FLUSH zero rows.
- Consumer stalls 20 cycles with NB=2: XFER pauses with both banks valid. No data loss; the ordering of rows 0..7 is preserved.
- clear_i asserted mid-XFER: next cycle busy_o=0, out_valid_o=0, load_ready_o=0. A new start_i runs a clean tile.

Source files
------------

// File: rtl/redmule_pkg.sv
// rtl/redmule_pkg.sv - shared types and defaults for the RedMulE X stream buffer
package redmule_pkg;

    localparam int unsigned X_STREAM_NB_DEFAULT = 2;
    // Configuration fields are stored wider than any port so compares never truncate
    localparam int unsigned X_STREAM_CFG_BITS   = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        XFER,
        FLUSH,
        DRAIN
    } x_stream_state_e;

    typedef struct packed {
        logic [X_STREAM_CFG_BITS-1:0] width;
        logic [X_STREAM_CFG_BITS-1:0] height;
        logic [X_STREAM_CFG_BITS-1:0] slots;
    } x_stream_cfg_t;

endpackage

// File: rtl/redmule_x_pad_scm.sv
// rtl/redmule_x_pad_scm.sv - W-row pad memory, row write port and column read port
module redmule_x_pad_scm #(
    parameter int unsigned DW        = 288,
    parameter int unsigned BITW      = 16,
    parameter int unsigned W         = 12,
    parameter int unsigned TOT_DEPTH = DW / BITW,
    parameter int unsigned PA        = (W > 1) ? $clog2(W) : 1,
    parameter int unsigned CA        = $clog2(TOT_DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [PA-1:0]       waddr_i,
    input  logic [DW-1:0]       wdata_i,
    input  logic [CA-1:0]       col_i,
    output logic [W*BITW-1:0]   col_o
);

    logic [DW-1:0] mem_q [W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Column c gathers element c of every stored row; out-of-range columns read as zero
    always_comb begin
        col_o = '0;
        for (int w = 0; w < W; w++) begin
            for (int t = 0; t < TOT_DEPTH; t++) begin
                if (col_i == CA'(t)) begin
                    col_o[w*BITW +: BITW] = mem_q[w][t*BITW +: BITW];
                end
            end
        end
    end

endmodule

// File: rtl/redmule_x_stream_banks.sv
// rtl/redmule_x_stream_banks.sv - NB staging banks of H rows, one write port, full-bank read
module redmule_x_stream_banks #(
    parameter int unsigned BITW = 16,
    parameter int unsigned H    = 4,
    parameter int unsigned W    = 12,
    parameter int unsigned NB   = 2,
    parameter int unsigned HA   = (H > 1) ? $clog2(H) : 1,
    parameter int unsigned BA   = $clog2(NB)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [BA-1:0]         wbank_i,
    input  logic [HA-1:0]         wrow_i,
    input  logic [W*BITW-1:0]     wdata_i,
    input  logic [BA-1:0]         rbank_i,
    output logic [W*H*BITW-1:0]   rdata_o
);

    logic [W*BITW-1:0] mem_q [NB][H];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wbank_i][wrow_i] <= wdata_i;
        end
    end

    // Output layout is [W][H][BITW]: element (w, h) sits at index w*H + h
    always_comb begin
        rdata_o = '0;
        for (int w = 0; w < W; w++) begin
            for (int h = 0; h < H; h++) begin
                rdata_o[(w*H + h)*BITW +: BITW] = mem_q[rbank_i][h][w*BITW +: BITW];
            end
        end
    end

endmodule

// File: rtl/redmule_x_stream_buffer.sv
// rtl/redmule_x_stream_buffer.sv - X staging buffer: pad load, transpose into NB banks; stall counter under REDMULE_X_STREAM_BUF_PERF_EN
module redmule_x_stream_buffer
    import redmule_pkg::*;
#(
    parameter int unsigned DW        = 288,
    parameter int unsigned BITW      = 16,
    parameter int unsigned H         = 4,
    parameter int unsigned W         = 12,
    parameter int unsigned NB        = X_STREAM_NB_DEFAULT,
    parameter int unsigned TOT_DEPTH = DW / BITW
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          start_i,
    input  logic [$clog2(W):0]            cfg_width_i,
    input  logic [$clog2(TOT_DEPTH):0]    cfg_height_i,
    input  logic [$clog2(TOT_DEPTH):0]    cfg_slots_i,
    input  logic                          load_valid_i,
    output logic                          load_ready_o,
    input  logic [DW-1:0]                 load_data_i,
    input  logic                          shift_i,
    output logic                          out_valid_o,
    output logic [W*H*BITW-1:0]           x_buffer_o,
    output logic                          tile_done_o,
    output logic                          busy_o,
    output logic [31:0]                   perf_stall_o
);

    localparam int unsigned CA = $clog2(TOT_DEPTH) + 1;
    localparam int unsigned PA = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned HA = (H > 1) ? $clog2(H) : 1;
    localparam int unsigned BA = $clog2(NB);
    localparam int unsigned CB = X_STREAM_CFG_BITS;

    x_stream_state_e   state_q;
    x_stream_cfg_t     cfg_q;
    logic [CB-1:0]     w_idx_q;
    logic [CB-1:0]     c_q;
    logic [HA-1:0]     hw_q;
    logic [HA-1:0]     hr_q;
    logic [BA-1:0]     wb_q;
    logic [BA-1:0]     rb_q;
    logic [NB-1:0]     bank_valid_q;
    logic [NB-1:0]     bank_valid_d;
    logic              tile_done_q;

    logic              pad_we;
    logic [W*BITW-1:0] pad_col;
    logic [W*BITW-1:0] row_data;
    logic [W*H*BITW-1:0] bank_rdata;
    logic              xfer_active;
    logic              bank_we;
    logic              bank_wrap;
    logic              rd_pop;
    logic              rd_last;

    assign load_ready_o = (state_q == LOAD) && (w_idx_q < cfg_q.width);
    assign pad_we       = load_ready_o && load_valid_i;

    // Writes only ever target a bank the consumer has released
    assign xfer_active  = (state_q == XFER) && (c_q != cfg_q.slots);
    assign bank_we      = (xfer_active || (state_q == FLUSH)) && !bank_valid_q[wb_q];
    assign bank_wrap    = bank_we && (hw_q == HA'(H - 1));

    assign rd_pop       = shift_i && bank_valid_q[rb_q];
    assign rd_last      = rd_pop && (hr_q == HA'(H - 1));

    assign out_valid_o  = bank_valid_q[rb_q];
    assign busy_o       = (state_q != IDLE);
    assign tile_done_o  = tile_done_q;
    assign x_buffer_o   = out_valid_o ? bank_rdata : '0;

    redmule_x_pad_scm #(
        .DW        (DW),
        .BITW      (BITW),
        .W         (W),
        .TOT_DEPTH (TOT_DEPTH),
        .PA        (PA),
        .CA        (CA)
    ) i_pad (
        .clk_i   (clk_i),
        .we_i    (pad_we),
        .waddr_i (w_idx_q[PA-1:0]),
        .wdata_i (load_data_i),
        .col_i   (c_q[CA-1:0]),
        .col_o   (pad_col)
    );

    // Columns past the valid height and elements past the valid width are zero-masked; FLUSH rows are all zero
    always_comb begin
        row_data = '0;
        if ((state_q == XFER) && (c_q < cfg_q.height)) begin
            for (int w = 0; w < W; w++) begin
                if (CB'(w) < cfg_q.width) begin
                    row_data[w*BITW +: BITW] = pad_col[w*BITW +: BITW];
                end
            end
        end
    end

    redmule_x_stream_banks #(
        .BITW (BITW),
        .H    (H),
        .W    (W),
        .NB   (NB),
        .HA   (HA),
        .BA   (BA)
    ) i_banks (
        .clk_i   (clk_i),
        .we_i    (bank_we),
        .wbank_i (wb_q),
        .wrow_i  (hw_q),
        .wdata_i (row_data),
        .rbank_i (rb_q),
        .rdata_o (bank_rdata)
    );

    always_comb begin
        bank_valid_d = bank_valid_q;
        if (bank_wrap) begin
            bank_valid_d[wb_q] = 1'b1;
        end
        if (rd_last) begin
            bank_valid_d[rb_q] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cfg_q        <= '0;
            w_idx_q      <= '0;
            c_q          <= '0;
            hw_q         <= '0;
            hr_q         <= '0;
            wb_q         <= '0;
            rb_q         <= '0;
            bank_valid_q <= '0;
            tile_done_q  <= 1'b0;
        end else if (clear_i) begin
            state_q      <= IDLE;
            cfg_q        <= '0;
            w_idx_q      <= '0;
            c_q          <= '0;
            hw_q         <= '0;
            hr_q         <= '0;
            wb_q         <= '0;
            rb_q         <= '0;
            bank_valid_q <= '0;
            tile_done_q  <= 1'b0;
        end else begin
            tile_done_q  <= 1'b0;
            bank_valid_q <= bank_valid_d;

            if (bank_we) begin
                hw_q <= bank_wrap ? '0 : hw_q + HA'(1);
            end
            if (bank_wrap) begin
                wb_q <= wb_q + BA'(1);
            end
            if (rd_pop) begin
                hr_q <= rd_last ? '0 : hr_q + HA'(1);
            end
            if (rd_last) begin
                rb_q <= rb_q + BA'(1);
            end

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cfg_q.width  <= CB'(cfg_width_i);
                        cfg_q.height <= CB'(cfg_height_i);
                        cfg_q.slots  <= CB'(cfg_slots_i);
                        state_q      <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_idx_q == cfg_q.width) begin
                        state_q <= XFER;
                    end else if (pad_we) begin
                        w_idx_q <= w_idx_q + CB'(1);
                    end
                end
                XFER: begin
                    if (c_q == cfg_q.slots) begin
                        state_q <= (hw_q != '0) ? FLUSH : DRAIN;
                    end else if (bank_we) begin
                        c_q <= c_q + CB'(1);
                    end
                end
                FLUSH: begin
                    if (bank_wrap) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bank_valid_q == '0) begin
                        tile_done_q <= 1'b1;
                        w_idx_q     <= '0;
                        c_q         <= '0;
                        state_q     <= LOAD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef REDMULE_X_STREAM_BUF_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else if (clear_i || start_i) begin
            perf_q <= '0;
        end else if (busy_o && !out_valid_o && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_o = perf_q;
`else
    assign perf_stall_o = '0;
`endif

endmodule
